// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - opcodes, frame widths and FSM state type for the SPI RAM master
package spi_ram_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        GAP,
        RECV,
        END
    } state_t;

endpackage

// File: rtl/spi_master_shifter.sv
// rtl/spi_master_shifter.sv - TX/RX shift registers and bit counter for the SPI RAM master
module spi_master_shifter
    import spi_ram_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [FRAME_W-1:0] frame,
    input  logic               tx_shift,
    input  logic               rx_shift,
    input  logic               cnt_en,
    input  logic               cnt_clr,
    input  logic               miso,
    output logic               tx_bit,
    output logic [DATA_W-1:0]  rx_data,
    output logic [3:0]         bit_cnt
);

    logic [FRAME_W-1:0] tx_sr;
    logic [DATA_W-1:0]  rx_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
        end else begin
            if (load)
                tx_sr <= frame;
            else if (tx_shift)
                tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};

            if (rx_shift)
                rx_sr <= {rx_sr[DATA_W-2:0], miso};

            // load doubles as a counter clear so every frame starts at bit 0
            if (load || cnt_clr)
                bit_cnt <= '0;
            else if (cnt_en)
                bit_cnt <= bit_cnt + 4'd1;
        end
    end

    assign tx_bit  = tx_sr[FRAME_W-1];
    assign rx_data = rx_sr;

endmodule

// File: rtl/spi_ram_master.sv
// rtl/spi_ram_master.sv - command-driven SPI master for the SPI RAM stage
// Optional SPI_RAM_MASTER_SEQ_CHK_EN: flag rd-data commands not preceded by an rd-addr frame.
module spi_ram_master
    import spi_ram_pkg::*;
#(
    parameter int RD_GAP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              seq_err,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] rsp_q;
    logic              load;
    logic              tx_shift;
    logic              rx_shift;
    logic              cnt_en;
    logic              cnt_clr;
    logic              tx_bit;
    logic [DATA_W-1:0] rx_data;
    logic [3:0]        bit_cnt;

    spi_master_shifter u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .frame    ({cmd_op, cmd_data}),
        .tx_shift (tx_shift),
        .rx_shift (rx_shift),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .miso     (MISO),
        .tx_bit   (tx_bit),
        .rx_data  (rx_data),
        .bit_cnt  (bit_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= OP_WR_ADDR;
            rsp_q <= '0;
        end else begin
            state <= state_nxt;
            if (load)
                op_q <= cmd_op;
            if (state == END && op_q == OP_RD_DATA)
                rsp_q <= rx_data;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        tx_shift  = 1'b0;
        rx_shift  = 1'b0;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    load      = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                tx_shift = 1'b1;
                cnt_en   = 1'b1;
                if (bit_cnt == 4'(FRAME_W - 1)) begin
                    cnt_clr   = 1'b1;
                    state_nxt = (op_q == OP_RD_DATA) ? GAP : END;
                end
            end
            GAP: begin
                cnt_en = 1'b1;
                if (bit_cnt == 4'(RD_GAP - 1)) begin
                    cnt_clr   = 1'b1;
                    state_nxt = RECV;
                end
            end
            RECV: begin
                rx_shift = 1'b1;
                cnt_en   = 1'b1;
                if (bit_cnt == 4'(DATA_W - 1)) begin
                    cnt_clr   = 1'b1;
                    state_nxt = END;
                end
            end
            END: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign SS_n      = !((state == SEND) || (state == GAP) || (state == RECV));
    assign MOSI      = (state == SEND) && tx_bit;
    assign rsp_valid = (state == END) && (op_q == OP_RD_DATA);
    // The fresh byte is presented straight from the RX register during END; rsp_q holds it afterwards.
    assign rsp_data  = rsp_valid ? rx_data : rsp_q;

`ifdef SPI_RAM_MASTER_SEQ_CHK_EN
    logic rd_armed;
    logic seq_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_armed  <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            seq_err_q <= load && (cmd_op == OP_RD_DATA) && !rd_armed;
            if (state == END) begin
                if (op_q == OP_RD_ADDR)
                    rd_armed <= 1'b1;
                else if (op_q == OP_RD_DATA)
                    rd_armed <= 1'b0;
            end
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_ram_master.sv
// tb/tb_spi_ram_master.sv - self-checking bench: per-cycle frame model, SPI RAM slave, directed commands
module tb_spi_ram_master;

    localparam int RD_GAP = 2;
`ifdef SPI_RAM_MASTER_SEQ_CHK_EN
    localparam int SEQ_ON = 1;
`else
    localparam int SEQ_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       seq_err;
    logic       SS_n;
    logic       MOSI;
    logic       MISO = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int seq_seen = 0;
    int rv_seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_ram_master #(.RD_GAP(RD_GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .seq_err   (seq_err),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Expected outputs, one entry per clock cycle of an in-flight command; empty queue means idle.
    typedef struct {
        logic       ss;
        logic       mosi;
        logic       busy;
        logic       rdy;
        logic       rv;
        logic       se;
        logic [7:0] rd;
    } exp_t;

    exp_t       q[$];
    logic [7:0] m_mem [256];
    logic [7:0] m_addr = 8'h00;
    logic [7:0] m_last = 8'h00;
    logic       m_flag = 1'b0;

    function automatic void push_frame(input logic [1:0] op, input logic [7:0] d);
        exp_t       e;
        logic [9:0] fr;
        logic [7:0] nv;
        logic       seq;
        fr  = {op, d};
        nv  = m_last;
        seq = 1'b0;
        case (op)
            2'b00: m_addr = d;
            2'b01: m_mem[m_addr] = d;
            2'b10: begin m_addr = d; m_flag = 1'b1; end
            default: begin nv = m_mem[m_addr]; seq = !m_flag; m_flag = 1'b0; end
        endcase
        seq    = seq && (SEQ_ON != 0);
        e.ss   = 1'b0;
        e.busy = 1'b1;
        e.rdy  = 1'b0;
        e.rv   = 1'b0;
        e.rd   = m_last;
        for (int i = 0; i < 10; i++) begin
            e.mosi = fr[9-i];
            e.se   = (i == 0) && seq;
            q.push_back(e);
        end
        e.mosi = 1'b0;
        e.se   = 1'b0;
        if (op == 2'b11)
            for (int i = 0; i < RD_GAP + 8; i++) q.push_back(e);
        e.ss = 1'b1;
        e.rv = (op == 2'b11);
        e.rd = nv;
        q.push_back(e);
        m_last = nv;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_last = 8'h00;
            m_flag = 1'b0;
        end else if (q.size() > 0) begin
            void'(q.pop_front());
        end else if (cmd_valid) begin
            push_frame(cmd_op, cmd_data);
        end
    end

    always @(negedge clk) begin : compare
        exp_t e;
        if (q.size() > 0) begin
            e = q[0];
        end else begin
            e.ss = 1'b1; e.mosi = 1'b0; e.busy = 1'b0; e.rdy = 1'b1;
            e.rv = 1'b0; e.se = 1'b0; e.rd = m_last;
        end
        chk("ss_n",      16'(SS_n),      16'(e.ss));
        chk("mosi",      16'(MOSI),      16'(e.mosi));
        chk("busy",      16'(busy),      16'(e.busy));
        chk("cmd_ready", 16'(cmd_ready), 16'(e.rdy));
        chk("rsp_valid", 16'(rsp_valid), 16'(e.rv));
        chk("rsp_data",  16'(rsp_data),  16'(e.rd));
        chk("seq_err",   16'(seq_err),   16'(e.se));
        if (seq_err) seq_seen++;
        if (rsp_valid) rv_seen++;
    end

    // SPI RAM slave: takes MOSI while selected, returns the addressed byte after the read gap.
    logic [7:0] s_mem [256];
    logic [7:0] s_addr = 8'h00;
    logic [7:0] s_out = 8'h00;
    logic [9:0] s_sh = 10'h000;
    int         s_cnt = 0;

    always @(negedge clk) begin
        if (SS_n) begin
            s_cnt = 0;
        end else begin
            if (s_cnt < 10) s_sh = {s_sh[8:0], MOSI};
            s_cnt++;
            if (s_cnt == 10) begin
                case (s_sh[9:8])
                    2'b00:   s_addr = s_sh[7:0];
                    2'b01:   s_mem[s_addr] = s_sh[7:0];
                    2'b10:   s_addr = s_sh[7:0];
                    default: s_out = s_mem[s_addr];
                endcase
            end
        end
        if (!SS_n && s_cnt >= 11 + RD_GAP && s_cnt <= 18 + RD_GAP)
            MISO = s_out[18 + RD_GAP - s_cnt];
        else
            MISO = 1'($urandom);
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] d);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("handshake_in_time", 16'(n < 100), 16'd1);
        @(posedge clk);
        @(negedge clk);
        hs_cyc    = cyc - 1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = 8'($urandom);
    endtask

    task automatic wait_rsp(output int lat, output logic [7:0] d);
        lat = -1;
        d   = 8'h00;
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid) begin
                lat = cyc - hs_cyc;
                d   = rsp_data;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int         lat;
        logic [7:0] d;
        logic [9:0] bits;
        int         nh;
        int         rises;
        logic       prev_ss;

        for (int i = 0; i < 256; i++) begin
            s_mem[i] = ~8'(i);
            m_mem[i] = ~8'(i);
        end
        s_mem[8'h3C] = 8'hA5;
        m_mem[8'h3C] = 8'hA5;

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ss_n",     16'(SS_n),     16'd1);
        chk("rst_mosi",     16'(MOSI),     16'd0);
        chk("rst_rsp_data", 16'(rsp_data), 16'h00);
        chk("rst_busy",     16'(busy),     16'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 16'(cmd_ready), 16'd1);

        // write address 0x5A: MOSI 00_0101_1010, END in cycle 11, ready in cycle 12
        issue(2'b00, 8'h5A);
        bits = '0;
        for (int i = 0; i < 10; i++) begin
            bits = {bits[8:0], MOSI};
            @(negedge clk);
        end
        chk("wr_addr_mosi",    16'(bits), 16'h05A);
        chk("wr_addr_end_c11", 16'({SS_n, busy, rsp_valid}), 16'b110);
        @(negedge clk);
        chk("wr_addr_ready_c12", 16'(cmd_ready), 16'd1);

        // rd-data without a preceding rd-addr: byte still returned from 0x5A
        seq_seen = 0;
        issue(2'b11, 8'h00);
        wait_rsp(lat, d);
        chk("noarm_rsp_lat",  16'(lat), 16'(11 + RD_GAP + 8));
        chk("noarm_rsp_data", 16'(d),   16'hA5);
        chk("noarm_seq_err",  16'(seq_seen), 16'(SEQ_ON));

        // rd-addr 0x3C then rd-data -> 0xA5 at cycle 11+RD_GAP+8, no seq_err
        issue(2'b10, 8'h3C);
        seq_seen = 0;
        issue(2'b11, 8'h00);
        wait_rsp(lat, d);
        chk("rd_rsp_lat",  16'(lat), 16'd21);
        chk("rd_rsp_data", 16'(d),   16'hA5);
        chk("rd_seq_err",  16'(seq_seen), 16'd0);

        // cmd_valid held for three back-to-back writes
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_data  = 8'h11;
        nh        = 0;
        rises     = 0;
        prev_ss   = SS_n;
        for (int i = 0; i < 80 && nh < 3; i++) begin
            if (cmd_ready) nh++;
            @(negedge clk);
            if (SS_n && !prev_ss) rises++;
            prev_ss  = SS_n;
            cmd_data = cmd_data + 8'h11;
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (SS_n && !prev_ss) rises++;
            prev_ss = SS_n;
        end
        chk("b2b_handshakes", 16'(nh),    16'd3);
        chk("b2b_ss_rises",   16'(rises), 16'd3);

        // full loop through the RAM slave
        issue(2'b00, 8'h10);
        issue(2'b01, 8'h77);
        issue(2'b10, 8'h10);
        issue(2'b11, 8'h00);
        wait_rsp(lat, d);
        chk("loop_rsp_data", 16'(d),   16'h77);
        chk("loop_rsp_lat",  16'(lat), 16'(11 + RD_GAP + 8));

        // reset in bit 5 of a rd-data frame
        @(negedge clk);
        issue(2'b10, 8'h10);
        issue(2'b11, 8'h00);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_ss_n",      16'(SS_n),      16'd1);
        chk("abort_mosi",      16'(MOSI),      16'd0);
        chk("abort_busy",      16'(busy),      16'd0);
        chk("abort_rsp_valid", 16'(rsp_valid), 16'd0);
        chk("abort_rsp_data",  16'(rsp_data),  16'h00);
        @(negedge clk);
        rv_seen = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 16'(cmd_ready), 16'd1);
        repeat (30) @(negedge clk);
        chk("abort_no_rsp", 16'(rv_seen), 16'd0);
        seq_seen = 0;
        issue(2'b11, 8'h00);
        wait_rsp(lat, d);
        chk("post_abort_rsp_data", 16'(d), 16'h77);
        chk("post_abort_seq_err",  16'(seq_seen), 16'(SEQ_ON));

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
